// File: rtl/queue_push_arbiter.sv
// Round-robin arbiter sharing one queue push port among NUM_REQ producers,
// with a one-entry staging register so data is stable before pushReq_OUT rises.
module queue_push_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_IN,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData_IN,
    output logic [NUM_REQ-1:0]            grant_OUT,
    output logic                          pushReq_OUT,
    output logic [DATA_WIDTH-1:0]         data_OUT,
    output logic [IDX_WIDTH-1:0]          srcIdx_OUT,
    input  logic                          fullFlag_IN,
    input  logic                          flush_IN,
    output logic [CNT_WIDTH-1:0]          acceptCount_OUT
);

    logic                  r_stage_valid;
    logic [DATA_WIDTH-1:0] r_stage_data;
    logic [IDX_WIDTH-1:0]  r_stage_src;
    logic [IDX_WIDTH-1:0]  r_last_win;
    logic [CNT_WIDTH-1:0]  r_accept_cnt;

    logic                  w_drain;
    logic                  w_stage_free;
    logic                  w_enable;
    logic                  w_found;
    logic                  w_take;
    logic [IDX_WIDTH-1:0]  w_win;
    int                    w_idx;

    assign w_drain      = r_stage_valid && !fullFlag_IN;
    assign w_stage_free = !r_stage_valid || w_drain;
    assign w_enable     = w_stage_free && !flush_IN && !reset;
    assign w_take       = w_enable && w_found;

    // Search starts one past the last winner and wraps explicitly, so
    // non-power-of-2 producer counts rotate correctly.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = int'(r_last_win) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_IN[w_idx[IDX_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant_OUT = '0;
        if (w_take) begin
            grant_OUT[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
            r_stage_src   <= '0;
            r_last_win    <= IDX_WIDTH'(NUM_REQ - 1);
            r_accept_cnt  <= '0;
        end else if (flush_IN) begin
            r_stage_valid <= 1'b0;
        end else begin
            if (w_drain && (r_accept_cnt != {CNT_WIDTH{1'b1}})) begin
                r_accept_cnt <= r_accept_cnt + 1'b1;
            end
            if (w_take) begin
                r_stage_valid <= 1'b1;
                r_stage_data  <= reqData_IN[w_win*DATA_WIDTH +: DATA_WIDTH];
                r_stage_src   <= w_win;
                r_last_win    <= w_win;
            end else if (w_drain) begin
                r_stage_valid <= 1'b0;
            end
        end
    end

    assign pushReq_OUT     = r_stage_valid;
    assign data_OUT        = r_stage_data;
    assign srcIdx_OUT      = r_stage_src;
    assign acceptCount_OUT = r_accept_cnt;

endmodule

// File: tb/tb_queue_push_arbiter.sv
// Self-checking bench for queue_push_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_queue_push_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  reqData;
    logic              full;
    logic              flush;

    logic [NR-1:0]     grant, sat_grant;
    logic              push, sat_push;
    logic [DW-1:0]     data, sat_data;
    logic [IW-1:0]     src, sat_src;
    logic [CW-1:0]     count;
    logic [CWS-1:0]    sat_count;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_src   = 0;
    int            m_last  = NR - 1;
    int            m_count = 0;

    queue_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .req_IN(req), .reqData_IN(reqData),
        .grant_OUT(grant), .pushReq_OUT(push), .data_OUT(data), .srcIdx_OUT(src),
        .fullFlag_IN(full), .flush_IN(flush), .acceptCount_OUT(count)
    );

    queue_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(IW), .CNT_WIDTH(CWS)) dut_sat (
        .clk(clk), .reset(reset), .req_IN(req), .reqData_IN(reqData),
        .grant_OUT(sat_grant), .pushReq_OUT(sat_push), .data_OUT(sat_data), .srcIdx_OUT(sat_src),
        .fullFlag_IN(full), .flush_IN(flush), .acceptCount_OUT(sat_count)
    );

    function automatic int model_winner();
        int k;
        if (reset || flush || (m_valid && full)) return -1;
        for (int off = 1; off <= NR; off++) begin
            k = (m_last + off) % NR;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] model_grant();
        int w;
        logic [NR-1:0] g;
        g = '0;
        w = model_winner();
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    function automatic int exp_cnt(int lim);
        return (m_count > lim) ? lim : m_count;
    endfunction

    task automatic model_edge();
        int w;
        w = model_winner();
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_last = NR - 1; m_count = 0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else begin
            if (m_valid && !full) begin
                m_count++;
                m_valid = 1'b0;
            end
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = reqData[w*DW +: DW];
                m_src   = w;
                m_last  = w;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '1; flush = 1'b0; full = 1'b0;
        #1;
        n_cmp++;
        if (grant !== '0) begin
            n_err++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000);
        end
        advance();
        advance();
        reset = 1'b0; req = '0;
        #1;
        n_cmp++;
        if ({push, data, src, count, sat_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got push=%b data=%h src=%0d cnt=%0d sat=%0d expected all zero",
                     push, data, src, count, sat_count);
        end
        advance();
    endtask

    task automatic test_single();
        req = 4'b0100; reqData[2*DW +: DW] = 8'h5A;
        #1;
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_err++; $display("FAIL single_grant: got %b expected 0100", grant);
        end
        advance();
        req = '0;
        #1;
        n_cmp++;
        if ({push, data, src} !== {1'b1, 8'h5A, 2'd2}) begin
            n_err++; $display("FAIL single_stage: got push=%b data=%h src=%0d expected 1/5a/2", push, data, src);
        end
        advance();
        #1;
        n_cmp++;
        if (count !== 16'd1 || push !== 1'b0) begin
            n_err++; $display("FAIL single_count: got cnt=%0d push=%b expected 1/0", count, push);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] eg;
        req = '1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = 8'($urandom);
            #1;
            eg = model_grant();
            n_cmp++;
            if (grant !== eg) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, grant, eg);
            end
            n_cmp++;
            if (c > 0 && ({push, data, src} !== {1'b1, m_data, IW'(m_src)} || count !== CW'(m_count))) begin
                n_err++;
                $display("FAIL rr_push[%0d]: got push=%b data=%h src=%0d cnt=%0d expected 1/%h/%0d/%0d",
                         c, push, data, src, count, m_data, m_src, m_count);
            end
            advance();
        end
    endtask

    task automatic test_full_hold();
        req = 4'b0001; reqData[0 +: DW] = 8'h33; full = 1'b0;
        advance();
        full = 1'b1; req = 4'b0010; reqData[DW +: DW] = 8'hC7;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (grant !== '0 || data !== 8'h33 || push !== 1'b1) begin
                n_err++;
                $display("FAIL full_hold[%0d]: got grant=%b data=%h push=%b expected 0000/33/1", c, grant, data, push);
            end
            advance();
        end
        full = 1'b0;
        #1;
        n_cmp++;
        if (grant !== 4'b0010 || push !== 1'b1) begin
            n_err++; $display("FAIL full_release_grant: got grant=%b push=%b expected 0010/1", grant, push);
        end
        advance();
        req = '0;
        #1;
        n_cmp++;
        if ({push, data, src} !== {1'b1, 8'hC7, 2'd1} || count !== CW'(m_count)) begin
            n_err++;
            $display("FAIL full_release_data: got push=%b data=%h src=%0d cnt=%0d expected 1/c7/1/%0d",
                     push, data, src, count, m_count);
        end
        advance();
    endtask

    task automatic test_flush();
        logic [CW-1:0] cnt0;
        req = 4'b0001; reqData[0 +: DW] = 8'h11;
        advance();
        flush = 1'b1;
        #1;
        cnt0 = CW'(m_count);
        n_cmp++;
        if (grant !== '0 || push !== 1'b1) begin
            n_err++; $display("FAIL flush_grant: got grant=%b push=%b expected 0000/1", grant, push);
        end
        advance();
        flush = 1'b0;
        #1;
        n_cmp++;
        if (push !== 1'b0 || count !== cnt0 || grant !== 4'b0001) begin
            n_err++;
            $display("FAIL flush_after: got push=%b cnt=%0d grant=%b expected 0/%0d/0001", push, count, grant, cnt0);
        end
        advance();
        req = '0;
        #1;
        n_cmp++;
        if ({push, data, src} !== {1'b1, 8'h11, 2'd0}) begin
            n_err++; $display("FAIL flush_regrant: got push=%b data=%h src=%0d expected 1/11/0", push, data, src);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        req = 4'b0010; reqData[DW +: DW] = 8'hA5;
        advance();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (grant !== '0 || push !== 1'b1 || src !== 2'd1) begin
            n_err++; $display("FAIL midreset_pre: got grant=%b push=%b src=%0d expected 0000/1/1", grant, push, src);
        end
        advance();
        reset = 1'b0; req = '1;
        #1;
        n_cmp++;
        if ({push, data, src, count} !== '0 || grant !== 4'b0001) begin
            n_err++;
            $display("FAIL midreset_post: got push=%b data=%h src=%0d cnt=%0d grant=%b expected 0/00/0/0/0001",
                     push, data, src, count, grant);
        end
        advance();
        req = '0;
        advance();
    endtask

    task automatic test_random();
        logic [NR-1:0] pend;
        logic [NR-1:0] eg;
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            full  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    reqData[i*DW +: DW] = 8'($urandom);
                end
            end
            req = pend;
            #1;
            eg = model_grant();
            n_cmp++;
            if ({grant, push, data, src} !== {eg, m_valid, m_data, IW'(m_src)}) begin
                n_err++;
                $display("FAIL rand_main[%0d]: got g=%b p=%b d=%h s=%0d expected g=%b p=%b d=%h s=%0d",
                         c, grant, push, data, src, eg, m_valid, m_data, m_src);
            end
            n_cmp++;
            if ({sat_grant, sat_push, sat_data, sat_src} !== {eg, m_valid, m_data, IW'(m_src)}) begin
                n_err++;
                $display("FAIL rand_sat_stage[%0d]: got g=%b p=%b d=%h s=%0d expected g=%b p=%b d=%h s=%0d",
                         c, sat_grant, sat_push, sat_data, sat_src, eg, m_valid, m_data, m_src);
            end
            n_cmp++;
            if (count !== CW'(exp_cnt(65535)) || sat_count !== CWS'(exp_cnt(15))) begin
                n_err++;
                $display("FAIL rand_count[%0d]: got cnt=%0d sat=%0d expected %0d/%0d",
                         c, count, sat_count, exp_cnt(65535), exp_cnt(15));
            end
            pend = pend & ~eg;
            advance();
        end
        reset = 1'b0; flush = 1'b0; full = 1'b0; req = '0;
        advance();
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        advance();
        reset = 1'b0; req = '1; full = 1'b0; flush = 1'b0;
        for (int c = 0; c < 21; c++) begin
            for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = 8'($urandom);
            #1;
            n_cmp++;
            if (sat_count !== CWS'(exp_cnt(15))) begin
                n_err++; $display("FAIL sat_step[%0d]: got %0d expected %0d", c, sat_count, exp_cnt(15));
            end
            advance();
        end
        req = '0;
        #1;
        n_cmp++;
        if (sat_count !== 4'hF || count !== 16'd20) begin
            n_err++; $display("FAIL sat_final: got sat=%0d cnt=%0d expected 15/20", sat_count, count);
        end
        advance();
    endtask

    initial begin
        reset = 1'b1; req = '0; reqData = '0; full = 1'b0; flush = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_full_hold();
        test_flush();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/queue_push_arbiter.md
# queue_push_arbiter

Round-robin push arbiter that shares one circular queue's push port between `NUM_REQ` producers. It has a one-entry staging register, so every accepted item is presented to the queue with data already stable before `pushReq_OUT` rises. The arbiter sits between the producers (issue/decode ports) and the queue's `pushReq_IN`/`data_IN`/`fullFlag_OUT`/`flush_IN` pins. It guarantees starvation-free, in-order-per-producer insertion under queue back-pressure and flush.

## Interface
- `DATA_WIDTH`, 8, width of one queue entry in bits.
- `NUM_REQ`, 4, number of producers; 2..8.
- `IDX_WIDTH`, 2, bits to encode a producer index; must equal clog2(`NUM_REQ`).
- `CNT_WIDTH`, 16, width of the accepted-item counter.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req_IN`  in  NUM_REQ  bit i = producer i has valid data.
- `reqData_IN`  in  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant_OUT`  out  NUM_REQ  one-hot; combinational; bit i high = producer i's data is taken at this edge.
- `pushReq_OUT`  out  1  to queue `pushReq_IN`; registered (= stage valid).
- `data_OUT`  out  DATA_WIDTH  to queue `data_IN`; registered.
- `srcIdx_OUT`  out  IDX_WIDTH  producer index of the staged item; registered.
- `fullFlag_IN`  in  1  from queue `fullFlag_OUT`.
- `flush_IN`  in  1  pipeline flush; also wired to the queue's flush.
- `acceptCount_OUT`  out  CNT_WIDTH  items accepted by the queue since reset; saturating.

## Operation
- Staging register fields: `stageValid`, `stageData`, `stageSrc`. `pushReq_OUT`=`stageValid`, `data_OUT`=`stageData`, `srcIdx_OUT`=`stageSrc`.
- drain = `stageValid` && !`fullFlag_IN`. The queue writes at this edge.
- stageFree = !`stageValid` || drain.
- Arbitration is enabled when stageFree && !`flush_IN` && !`reset`.
- Round-robin: `lastWin` register (IDX_WIDTH). Search order is `lastWin`+1, `lastWin`+2, …, wrapping modulo `NUM_REQ` (explicit wrap, not a power-of-2 truncation). The first set `req_IN` bit in that order wins.
- When arbitration is enabled and a winner k exists:
  - `grant_OUT`[k]=1.
  - At the edge: `stageData`←`reqData_IN`[k], `stageSrc`←k, `stageValid`←1, `lastWin`←k.
- When enabled with no request: `grant_OUT`=0; at the edge `stageValid`←`stageValid` && !drain.
- When not enabled: `grant_OUT`=0; stage holds.
- Producer rule: hold `req_IN`[i] and its data stable until `grant_OUT`[i] is seen high at a clock edge; deassert or replace after that edge. The arbiter never grants without capturing.
- `acceptCount_OUT` increments by 1 on every drain edge and saturates at all-ones.
- `flush_IN`=1:
  - At the edge: `stageValid`←0, the staged item is discarded and not counted, `grant_OUT` is 0 throughout the cycle.
  - `lastWin` and `acceptCount_OUT` are unchanged.
- Simultaneous drain and grant (full throughput): the stage drains and reloads at the same edge. Sustains 1 item/cycle.

## Timing
- Reset values:
  - `grant_OUT`=0 (forced while `reset` is high), `pushReq_OUT`=0, `data_OUT`=0, `srcIdx_OUT`=0, `acceptCount_OUT`=0.
  - `lastWin`=`NUM_REQ`-1, so producer 0 has first priority.
- `reset` has priority over `flush_IN`, which has priority over arbitration. Reset mid-transfer drops the staged item.
- Latency: grant in cycle t → `pushReq_OUT`/`data_OUT` valid in cycle t+1 → queue writes at the end of t+1 if not full.
- `fullFlag_IN` high: stage holds unchanged, with `data_OUT` stable and `pushReq_OUT` high, and no grants. The first cycle with `fullFlag_IN` low drains the stage and may grant in the same cycle.
- `grant_OUT` depends combinationally on `req_IN`, `fullFlag_IN`, `flush_IN`, `reset` and state. No combinational path from `reqData_IN` to any output.

## Test plan
- Reset, then `req_IN`=4'b0100 with data 0x5A for one cycle:
  - `grant_OUT`=0100 in cycle 1.
  - `pushReq_OUT`=1, `data_OUT`=0x5A, `srcIdx_OUT`=2 in cycle 2.
  - `acceptCount_OUT`=1 in cycle 3.
- `req_IN`=1111 held, with each producer re-presenting data after every grant:
  - Grants in order 0,1,2,3,0,…
  - One push per cycle; count +1 each cycle.
- Stage valid with data 0x33, `fullFlag_IN`=1 for 5 cycles, `req_IN`=0010:
  - `grant_OUT`=0 and `data_OUT`=0x33 held for all 5 cycles.
  - When full deasserts: drain and grant[1] in the same cycle, next `data_OUT`=producer 1's data.
- Stage valid, `flush_IN`=1 for one cycle with `req_IN`=0001:
  - No grant; `pushReq_OUT`=0 next cycle; count unchanged.
  - Grant[0] occurs in the following cycle.
- Assert `reset` one cycle while stage valid and `lastWin`=1:
  - All outputs return to their reset values.
  - Next `req_IN`=1111 grants producer 0.
- `CNT_WIDTH`=4, drive 20 accepted pushes: `acceptCount_OUT` stops at 0xF.
